// File: rtl/alu_sched_if.sv
// One requester channel of the ALU scheduler: request {a,b,op} by valid/ready,
// response {result,err} by valid/ready.
interface alu_sched_if #(
   parameter int DW  = 4,
   parameter int OPW = 4,
   parameter int RW  = 6
);
   logic           req_valid;
   logic           req_ready;
   logic [DW-1:0]  req_a;
   logic [DW-1:0]  req_b;
   logic [OPW-1:0] req_op;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [RW-1:0]  rsp_result;
   logic           rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_err
   );
endinterface

// File: rtl/alu_sched.sv
// Two-requester round-robin front end for a single shared registered ALU.
// Screens illegal opcodes and divide/modulo by zero before they reach the ALU.
//
// state | meaning
// IDLE  | arbitrate and accept one request
// ISSUE | alu_v pulse with latched operands
// CAPT  | ALU result valid, sampled at end of cycle
// RESP  | response held to owner until consumed
module alu_sched #(
   parameter int DW     = 4,
   parameter int OPW    = 4,
   parameter int RW     = 6,
   parameter int MAX_OP = 9
) (
   input  logic           clk,
   input  logic           rst,
   alu_sched_if.slave     req0_if,
   alu_sched_if.slave     req1_if,
   output logic [DW-1:0]  alu_a_o,
   output logic [DW-1:0]  alu_b_o,
   output logic [OPW-1:0] alu_i_o,
   output logic           alu_v_o,
   input  logic [RW-1:0]  alu_s_i,
   output logic           busy_o
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]     state_q, state_d;
   logic           last_q, last_d;
   logic           owner_q, owner_d;
   logic [DW-1:0]  a_q, a_d, b_q, b_d;
   logic [OPW-1:0] op_q, op_d;
   logic [RW-1:0]  res_q, res_d;
   logic           err_q, err_d;

   logic           is_idle, win0, win1, acc, in_err, rsp_rdy;
   logic [DW-1:0]  in_a, in_b;
   logic [OPW-1:0] in_op;

   assign is_idle = (state_q == S_IDLE);
   // On contention the requester that did not win last time gets the grant.
   assign win1    = req1_if.req_valid & (~req0_if.req_valid | ~last_q);
   assign win0    = req0_if.req_valid & ~win1;
   assign acc     = is_idle & (win0 | win1);

   assign in_a    = win1 ? req1_if.req_a  : req0_if.req_a;
   assign in_b    = win1 ? req1_if.req_b  : req0_if.req_b;
   assign in_op   = win1 ? req1_if.req_op : req0_if.req_op;
   assign in_err  = (in_op > OPW'(MAX_OP)) |
                    (((in_op == OPW'(3)) | (in_op == OPW'(4))) & (in_b == '0));
   assign rsp_rdy = owner_q ? req1_if.rsp_ready : req0_if.rsp_ready;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (acc) begin
               owner_d = win1;
               last_d  = win1;
               a_d     = in_a;
               b_d     = in_b;
               op_d    = in_op;
               if (in_err) begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_CAPT;
         S_CAPT: begin
            res_d   = alu_s_i;
            err_d   = 1'b0;
            state_d = S_RESP;
         end
         S_RESP: if (rsp_rdy) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign busy_o  = ~is_idle;
   assign alu_v_o = (state_q == S_ISSUE);
   assign alu_a_o = busy_o ? a_q  : '0;
   assign alu_b_o = busy_o ? b_q  : '0;
   assign alu_i_o = busy_o ? op_q : '0;

   assign req0_if.req_ready  = is_idle & win0;
   assign req1_if.req_ready  = is_idle & win1;
   assign req0_if.rsp_valid  = (state_q == S_RESP) & ~owner_q;
   assign req1_if.rsp_valid  = (state_q == S_RESP) &  owner_q;
   assign req0_if.rsp_result = req0_if.rsp_valid ? res_q : '0;
   assign req1_if.rsp_result = req1_if.rsp_valid ? res_q : '0;
   assign req0_if.rsp_err    = req0_if.rsp_valid & err_q;
   assign req1_if.rsp_err    = req1_if.rsp_valid & err_q;
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: vector table of single transactions plus
// hand sequences for arbitration, backpressure and mid-operation reset.
module tb_alu_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] alu_a, alu_b, alu_i;
   logic       alu_v;
   logic [5:0] alu_s;
   logic       busy;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   alu_sched_if #(.DW(4), .OPW(4), .RW(6)) if0 ();
   alu_sched_if #(.DW(4), .OPW(4), .RW(6)) if1 ();

   alu_sched #(.DW(4), .OPW(4), .RW(6), .MAX_OP(9)) dut (
      .clk     (clk),
      .rst     (rst),
      .req0_if (if0),
      .req1_if (if1),
      .alu_a_o (alu_a),
      .alu_b_o (alu_b),
      .alu_i_o (alu_i),
      .alu_v_o (alu_v),
      .alu_s_i (alu_s),
      .busy_o  (busy)
   );

   function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] i);
      logic [7:0] x, y, r;
      x = {4'b0, a};
      y = {4'b0, b};
      case (i)
         4'd0: r = x + y;
         4'd1: r = x - y;
         4'd2: r = x * y;
         4'd3: r = (y == 0) ? 8'd0 : x / y;
         4'd4: r = (y == 0) ? 8'd0 : x % y;
         4'd5: r = x & y;
         4'd6: r = x | y;
         4'd7: r = ~x;
         4'd8: r = x << 1;
         default: r = x ^ y;
      endcase
      return r[5:0];
   endfunction

   // Registered ALU stand-in: result visible the cycle after the alu_v pulse.
   always @(posedge clk) begin
      if (rst) alu_s <= '0;
      else if (alu_v) alu_s <= alu_f(alu_a, alu_b, alu_i);
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      if (r == 0) begin
         if0.req_valid = v; if0.req_a = a; if0.req_b = b; if0.req_op = op;
      end else begin
         if1.req_valid = v; if1.req_a = a; if1.req_b = b; if1.req_op = op;
      end
   endtask

   task automatic set_rr(input int r, input logic v);
      if (r == 0) if0.rsp_ready = v;
      else        if1.rsp_ready = v;
   endtask

   function automatic logic get_ready(input int r);
      return (r == 0) ? if0.req_ready : if1.req_ready;
   endfunction
   function automatic logic get_rv(input int r);
      return (r == 0) ? if0.rsp_valid : if1.rsp_valid;
   endfunction
   function automatic logic [5:0] get_res(input int r);
      return (r == 0) ? if0.rsp_result : if1.rsp_result;
   endfunction
   function automatic logic get_err(input int r);
      return (r == 0) ? if0.rsp_err : if1.rsp_err;
   endfunction

   // One transaction end to end; lat counts cycles from accept to rsp_valid.
   task automatic send(input int r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output int lat, output int pulses, output logic [11:0] opnd,
                       output logic [5:0] res, output logic err);
      bit ok;
      lat = 0; pulses = 0; opnd = '0; res = '0; err = 1'b0; ok = 0;
      @(negedge clk);
      set_req(r, 1'b1, a, b, op);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (get_ready(r)) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
         set_req(r, 1'b0, 4'd0, 4'd0, 4'd0);
         return;
      end
      @(posedge clk); #1;
      set_req(r, 1'b0, 4'd0, 4'd0, 4'd0);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (alu_v) begin pulses++; opnd = {alu_a, alu_b, alu_i}; end
         if (get_rv(r)) begin ok = 1; break; end
      end
      if (!ok) begin
         check("rsp_timeout", 0, 1);
         return;
      end
      check("other_rsp_valid", int'(get_rv(1 - r)), 0);
      res = get_res(r);
      err = get_err(r);
      set_rr(r, 1'b1);
      @(posedge clk); #1;
      set_rr(r, 1'b0);
   endtask

   typedef struct {
      int         r;
      logic [3:0] a, b, op;
      logic [5:0] res;
      logic       err;
      int         lat;
      int         pulses;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int         lat, pulses;
      logic [11:0] opnd;
      logic [5:0] res;
      logic       err;
      int         order[$];
      int         seen;

      vecs[0] = '{0, 4'd3,  4'd4,  4'd0,  6'd7,   1'b0, 3, 1};
      vecs[1] = '{1, 4'd6,  4'd0,  4'd3,  6'd0,   1'b1, 1, 0};
      vecs[2] = '{1, 4'd7,  4'd2,  4'd12, 6'd0,   1'b1, 1, 0};
      vecs[3] = '{0, 4'd2,  4'd5,  4'd1,  6'h3D,  1'b0, 3, 1};
      vecs[4] = '{1, 4'd15, 4'd15, 4'd2,  6'h21,  1'b0, 3, 1};
      vecs[5] = '{0, 4'd5,  4'd3,  4'd9,  6'd6,   1'b0, 3, 1};
      vecs[6] = '{0, 4'd8,  4'd0,  4'd4,  6'd0,   1'b1, 1, 0};
      vecs[7] = '{1, 4'd9,  4'd2,  4'd3,  6'd4,   1'b0, 3, 1};
      vecs[8] = '{0, 4'd1,  4'd1,  4'd10, 6'd0,   1'b1, 1, 0};
      vecs[9] = '{1, 4'd9,  4'd4,  4'd4,  6'd1,   1'b0, 3, 1};

      set_req(0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1, 1'b0, 4'd0, 4'd0, 4'd0);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_busy",  int'(busy), 0);
      check("rst_alu_v", int'(alu_v), 0);
      check("rst_rsp0",  int'(if0.rsp_valid), 0);
      check("rst_rsp1",  int'(if1.rsp_valid), 0);
      rst = 1'b0;

      // Both requesters valid from the first cycle: req0 first, then strict alternation.
      @(negedge clk);
      set_req(0, 1'b1, 4'd1, 4'd1, 4'd0);
      set_req(1, 1'b1, 4'd2, 4'd2, 4'd0);
      set_rr(0, 1'b1);
      set_rr(1, 1'b1);
      for (int c = 0; c < 60; c++) begin
         #1;
         if (if0.req_ready) order.push_back(0);
         if (if1.req_ready) order.push_back(1);
         if (order.size() >= 4) break;
         @(negedge clk);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1, 1'b0, 4'd0, 4'd0, 4'd0);
      check("rr_grant_count", order.size(), 4);
      for (int k = 0; k < order.size(); k++) check("rr_grant_order", order[k], k % 2);
      repeat (6) @(negedge clk);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      check("rr_idle_after", int'(busy), 0);

      for (int i = 0; i < 10; i++) begin
         send(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, lat, pulses, opnd, res, err);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_alu_pulses", i), pulses, vecs[i].pulses);
         check($sformatf("v%0d_result", i), int'(res), int'(vecs[i].res));
         check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].err));
         if (!vecs[i].err)
            check($sformatf("v%0d_alu_operands", i), int'(opnd), int'({vecs[i].a, vecs[i].b, vecs[i].op}));
      end

      // Response backpressure: rsp0 held, req1 stalls then is served right after.
      @(negedge clk);
      set_req(0, 1'b1, 4'd1, 4'd2, 4'd0);
      #1;
      check("bp_req0_ready", int'(if0.req_ready), 1);
      @(posedge clk); #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1, 1'b1, 4'd4, 4'd5, 4'd0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (if0.rsp_valid) begin seen = 1; break; end
      end
      check("bp_rsp0_seen", seen, 1);
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp0_valid_hold", int'(if0.rsp_valid), 1);
         check("bp_rsp0_result_hold", int'(if0.rsp_result), 3);
         check("bp_req1_stalled", int'(if1.req_ready), 0);
         @(negedge clk);
      end
      set_rr(0, 1'b1);
      @(posedge clk); #1;
      set_rr(0, 1'b0);
      @(negedge clk);
      check("bp_req1_ready_next", int'(if1.req_ready), 1);
      @(posedge clk); #1;
      set_req(1, 1'b0, 4'd0, 4'd0, 4'd0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (if1.rsp_valid) begin seen = 1; break; end
      end
      check("bp_rsp1_seen", seen, 1);
      check("bp_rsp1_result", int'(if1.rsp_result), 9);
      set_rr(1, 1'b1);
      @(posedge clk); #1;
      set_rr(1, 1'b0);

      // Reset asserted while the FSM is in CAPT.
      @(negedge clk);
      set_req(0, 1'b1, 4'd3, 4'd4, 4'd0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      check("rst5_issue_alu_v", int'(alu_v), 1);
      @(negedge clk);
      check("rst5_capt_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      check("rst5_busy", int'(busy), 0);
      check("rst5_alu_v", int'(alu_v), 0);
      check("rst5_alu_a", int'(alu_a), 0);
      check("rst5_alu_i", int'(alu_i), 0);
      check("rst5_rsp0", int'(if0.rsp_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (if0.rsp_valid || if1.rsp_valid) seen++;
      end
      check("rst5_no_response", seen, 0);
      send(1, 4'd5, 4'd3, 4'd9, lat, pulses, opnd, res, err);
      check("rst5_after_latency", lat, 3);
      check("rst5_after_result", int'(res), 6);
      check("rst5_after_err", int'(err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end
endmodule
